// File: rtl/load_store_unit.sv
// Memory-access stage for the multi-cycle RV32I core: computes the effective address,
// drives the data RAM and returns an extended load result with a one-cycle done pulse.
module load_store_unit #(
    parameter int ADDR_WIDTH   = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  is_store,
    input  logic [2:0]            funct3,
    input  logic [31:0]           base,
    input  logic [31:0]           offset,
    input  logic [31:0]           store_data,
    output logic                  busy,
    output logic                  done,
    output logic                  fault,
    output logic [31:0]           load_data,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_byte_en,
    output logic [31:0]           mem_w_data,
    output logic                  mem_w_en,
    input  logic [31:0]           mem_r_data
);

    // state | meaning
    // IDLE  | waiting for start
    // ISSUE | address (and store data/enables) presented to the RAM
    // WAIT  | counting down the RAM read latency
    // RESP  | done pulse, result and fault valid
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [1:0] WAIT_INIT = 2'(READ_LATENCY - 1);

    state_t      state;
    logic [1:0]  ea_lo;
    logic [2:0]  op_f3;
    logic        op_store;
    logic [1:0]  wait_cnt;

    logic [31:0] ea;
    logic        req_fault;
    logic        legal_f3;
    logic        unused_ea;

    assign ea        = base + offset;
    assign unused_ea = ^ea[31:ADDR_WIDTH+2];

    always_comb begin
        legal_f3 = 1'b0;
        if (is_store) begin
            legal_f3 = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        end else begin
            legal_f3 = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                       (funct3 == 3'b100) || (funct3 == 3'b101);
        end
        req_fault = !legal_f3 ||
                    ((funct3[1:0] == 2'b01) && ea[0]) ||
                    ((funct3[1:0] == 2'b10) && (ea[1:0] != 2'b00));
    end

    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] lo,
                                            input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lo, 3'b000} +: 8];
        h = word[{lo[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return word;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            fault       <= 1'b0;
            load_data   <= '0;
            mem_addr    <= '0;
            mem_byte_en <= '0;
            mem_w_data  <= '0;
            mem_w_en    <= 1'b0;
            ea_lo       <= '0;
            op_f3       <= '0;
            op_store    <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ea_lo     <= ea[1:0];
                        op_f3     <= funct3;
                        op_store  <= is_store;
                        load_data <= '0;
                        busy      <= 1'b1;
                        if (req_fault) begin
                            // Faulting requests never touch the RAM.
                            state <= RESP;
                            done  <= 1'b1;
                            fault <= 1'b1;
                        end else begin
                            state    <= ISSUE;
                            mem_addr <= ea[ADDR_WIDTH+1:2];
                            if (is_store) begin
                                mem_w_en <= 1'b1;
                                case (funct3[1:0])
                                    2'b00: begin
                                        mem_byte_en <= 4'b0001 << ea[1:0];
                                        mem_w_data  <= {4{store_data[7:0]}};
                                    end
                                    2'b01: begin
                                        mem_byte_en <= 4'b0011 << ea[1:0];
                                        mem_w_data  <= {2{store_data[15:0]}};
                                    end
                                    default: begin
                                        mem_byte_en <= 4'b1111;
                                        mem_w_data  <= store_data;
                                    end
                                endcase
                            end else begin
                                mem_byte_en <= 4'b1111;
                            end
                        end
                    end
                end
                ISSUE: begin
                    mem_w_en <= 1'b0;
                    if (op_store) begin
                        state <= RESP;
                        done  <= 1'b1;
                    end else begin
                        state    <= WAIT;
                        wait_cnt <= WAIT_INIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        load_data <= extract(op_f3, ea_lo, mem_r_data);
                        state     <= RESP;
                        done      <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                RESP: begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    done        <= 1'b0;
                    fault       <= 1'b0;
                    mem_w_en    <= 1'b0;
                    mem_byte_en <= 4'b0000;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: two instances (read latency 1 and 3), each with its own RAM,
// checked every cycle against a transaction-level model plus literal expectations.
module tb_load_store_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst1, start0, start1;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] base, offset, store_data;

    logic        busy0, done0, fault0, w_en0;
    logic [31:0] ld0, w_data0, r_data0;
    logic [15:0] addr0;
    logic [3:0]  be0;
    logic        busy1, done1, fault1, w_en1;
    logic [31:0] ld1, w_data1, r_data1;
    logic [15:0] addr1;
    logic [3:0]  be1;

    load_store_unit #(.ADDR_WIDTH(16), .READ_LATENCY(1)) u_lsu0 (
        .clk(clk), .rst(rst0), .start(start0), .is_store(is_store), .funct3(funct3),
        .base(base), .offset(offset), .store_data(store_data),
        .busy(busy0), .done(done0), .fault(fault0), .load_data(ld0),
        .mem_addr(addr0), .mem_byte_en(be0), .mem_w_data(w_data0), .mem_w_en(w_en0),
        .mem_r_data(r_data0));

    load_store_unit #(.ADDR_WIDTH(16), .READ_LATENCY(3)) u_lsu1 (
        .clk(clk), .rst(rst1), .start(start1), .is_store(is_store), .funct3(funct3),
        .base(base), .offset(offset), .store_data(store_data),
        .busy(busy1), .done(done1), .fault(fault1), .load_data(ld1),
        .mem_addr(addr1), .mem_byte_en(be1), .mem_w_data(w_data1), .mem_w_en(w_en1),
        .mem_r_data(r_data1));

    function automatic logic [31:0] init_word(input int k, input int i);
        if (k == 0 && i == 4) return 32'hDEADBEEF;
        if (k == 0 && i == 5) return 32'h0BADF00D;
        if (k == 1 && i == 0) return 32'hCAFEF00D;
        if (k == 1 && i == 1) return 32'h11223344;
        return (32'(i) * 32'h01010101) ^ 32'h5A5A0000;
    endfunction

    // RAMs: address registered on the edge, q valid 1 (ram0) or 3 (ram1) edges later
    logic [31:0] ram0 [64];
    logic [31:0] ram1 [64];
    logic        ram_ready = 1'b0;
    logic [31:0] q0, q1_s0, q1_s1, q1_s2;
    assign r_data0 = q0;
    assign r_data1 = q1_s2;

    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 64; i++) begin
                ram0[i] <= init_word(0, i);
                ram1[i] <= init_word(1, i);
            end
            ram_ready <= 1'b1;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (w_en0 && be0[b]) ram0[addr0[5:0]][8*b +: 8] <= w_data0[8*b +: 8];
                if (w_en1 && be1[b]) ram1[addr1[5:0]][8*b +: 8] <= w_data1[8*b +: 8];
            end
        end
        q0    <= ram0[addr0[5:0]];
        q1_s0 <= ram1[addr1[5:0]];
        q1_s1 <= q1_s0;
        q1_s2 <= q1_s1;
    end

    // ---------------- model ----------------
    typedef struct {
        bit          valid;
        int          c0;
        int          d;
        int          abort;
        bit          st;
        bit          flt;
        logic [15:0] addr;
        logic [31:0] ld;
        logic [3:0]  be;
        logic [31:0] wd;
    } op_t;

    op_t         cur [2];
    logic [31:0] ref_mem [2][64];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          cmp_en = 1'b0;
    int          zero_cyc [2];
    int          last_done_cyc [2];
    logic [31:0] last_ld [2];
    logic        last_fault [2];
    int          dones_seen [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    function automatic bit model_fault(input bit st, input logic [2:0] f3, input logic [31:0] ea);
        bit legal;
        legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal) return 1'b1;
        if (f3[1:0] == 2'd1 && ea[0]) return 1'b1;
        if (f3[1:0] == 2'd2 && ea[1:0] != 2'd0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] lo,
                                               input logic [31:0] w);
        logic [31:0] v;
        case (f3)
            3'd0, 3'd4: begin
                v = (w >> (8 * lo)) & 32'hFF;
                if (f3 == 3'd0 && v[7]) v = v | 32'hFFFFFF00;
            end
            3'd1, 3'd5: begin
                v = (w >> (16 * lo[1])) & 32'hFFFF;
                if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    // Plans the transaction, updates the shadow memory and starts it on DUT k.
    task automatic issue(input int k, input bit st, input logic [2:0] f3, input logic [31:0] b,
                         input logic [31:0] o, input logic [31:0] sd, input bit wait_done);
        logic [31:0] ea;
        op_t         op;
        int          n;
        int          lane;
        ea       = b + o;
        op.valid = 1'b1;
        op.c0    = cyc;
        op.abort = 32'h7FFFFFFF;
        op.st    = st;
        op.addr  = ea[17:2];
        op.flt   = model_fault(st, f3, ea);
        op.ld    = '0;
        op.be    = '0;
        op.wd    = '0;
        if (op.flt) begin
            op.d = cyc + 1;
        end else if (st) begin
            op.d = cyc + 2;
            n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
            for (int i = 0; i < n; i++) begin
                lane = int'(ea[1:0]) + i;
                op.be[lane] = 1'b1;
                ref_mem[k][ea[7:2]][8*lane +: 8] = sd[8*i +: 8];
            end
            for (int j = 0; j < 4; j++) op.wd[8*j +: 8] = sd[8*(j % n) +: 8];
        end else begin
            op.d  = cyc + 2 + ((k == 0) ? 1 : 3);
            op.ld = model_load(f3, ea[1:0], ref_mem[k][ea[7:2]]);
        end
        cur[k]     = op;
        is_store   = st;
        funct3     = f3;
        base       = b;
        offset     = o;
        store_data = sd;
        if (k == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
        if (wait_done) begin
            while (cyc <= op.d) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic check_dut(input int k, input logic b, input logic d, input logic f,
                             input logic [31:0] ld, input logic [15:0] a, input logic [3:0] be,
                             input logic [31:0] wd, input logic we);
        op_t op;
        bit  in_flight;
        bit  wr_cyc;
        if (d === 1'b1) begin
            last_done_cyc[k] = cyc;
            last_ld[k]       = ld;
            last_fault[k]    = f;
            dones_seen[k]++;
        end
        if (!cmp_en) return;
        if (cyc == zero_cyc[k]) begin
            chk("abort_outputs", {b, d, f, we, be, a}, 24'h0);
            chk("abort_ld_wd", ld | wd, 32'h0);
            return;
        end
        op        = cur[k];
        in_flight = op.valid && cyc > op.c0 && cyc <= op.d && cyc < op.abort;
        wr_cyc    = op.valid && op.st && !op.flt && cyc == op.c0 + 1 && cyc < op.abort;
        chk("busy", 32'(b), 32'(in_flight));
        chk("done", 32'(d), 32'(in_flight && cyc == op.d));
        chk("w_en", 32'(we), 32'(wr_cyc));
        if (in_flight && !op.flt) chk("mem_addr", 32'(a), 32'(op.addr));
        if (wr_cyc) begin
            chk("byte_en", 32'(be), 32'(op.be));
            chk("w_data", wd, op.wd);
        end
        if (in_flight && cyc == op.d) begin
            chk("fault", 32'(f), 32'(op.flt));
            chk("load_data", ld, op.ld);
        end
    endtask

    always @(negedge clk) begin
        check_dut(0, busy0, done0, fault0, ld0, addr0, be0, w_data0, w_en0);
        check_dut(1, busy1, done1, fault1, ld1, addr1, be1, w_data1, w_en1);
    end

    int c0;
    int n_before;

    initial begin
        for (int k = 0; k < 2; k++) begin
            cur[k].valid     = 1'b0;
            zero_cyc[k]      = -1;
            dones_seen[k]    = 0;
            last_done_cyc[k] = -1;
            for (int i = 0; i < 64; i++) ref_mem[k][i] = init_word(k, i);
        end
        rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b0; start1 = 1'b0;
        is_store = 1'b0; funct3 = 3'd0; base = '0; offset = '0; store_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctl0", {busy0, done0, fault0, w_en0, be0}, 32'h0);
        chk("reset_dat0", ld0 | w_data0 | 32'(addr0), 32'h0);
        chk("reset_ctl1", {busy1, done1, fault1, w_en1, be1}, 32'h0);
        chk("reset_dat1", ld1 | w_data1 | 32'(addr1), 32'h0);
        @(posedge clk);
        #1;
        rst0 = 1'b0; rst1 = 1'b0;
        cmp_en = 1'b1;
        @(posedge clk);
        #1;

        // model pins
        chk("model_lb", model_load(3'd0, 2'd3, 32'hDEADBEEF), 32'hFFFFFFDE);
        chk("model_lhu", model_load(3'd5, 2'd2, 32'hDEADBEEF), 32'h0000DEAD);

        // LB 0x13 -> sign-extended 0xDE, done three cycles after start
        c0 = cyc;
        issue(0, 1'b0, 3'd0, 32'h10, 32'd3, 32'h0, 1'b1);
        chk("lb_data", last_ld[0], 32'hFFFFFFDE);
        chk("lb_latency", 32'(last_done_cyc[0] - c0), 32'd3);
        issue(0, 1'b0, 3'd5, 32'h14, 32'hFFFFFFFE, 32'h0, 1'b1);
        chk("lhu_data", last_ld[0], 32'h0000DEAD);
        issue(0, 1'b0, 3'd1, 32'h14, 32'hFFFFFFFE, 32'h0, 1'b1);
        chk("lh_data", last_ld[0], 32'hFFFFDEAD);

        // SH to the upper half of word 5, then read the word back
        c0 = cyc;
        issue(0, 1'b1, 3'd1, 32'h16, 32'h0, 32'h12345678, 1'b1);
        chk("sh_latency", 32'(last_done_cyc[0] - c0), 32'd2);
        issue(0, 1'b0, 3'd2, 32'h14, 32'h0, 32'h0, 1'b1);
        chk("lw_after_sh", last_ld[0], 32'h5678F00D);

        // faults: misaligned word, illegal store funct3, illegal load funct3, odd halfword
        c0 = cyc;
        issue(0, 1'b0, 3'd2, 32'h10, 32'h1, 32'h0, 1'b1);
        chk("lw_mis_fault", 32'(last_fault[0]), 32'd1);
        chk("lw_mis_latency", 32'(last_done_cyc[0] - c0), 32'd1);
        chk("lw_mis_data", last_ld[0], 32'h0);
        issue(0, 1'b1, 3'd3, 32'h20, 32'h0, 32'hFFFFFFFF, 1'b1);
        chk("st011_fault", 32'(last_fault[0]), 32'd1);
        issue(0, 1'b0, 3'd6, 32'h20, 32'h0, 32'h0, 1'b1);
        issue(0, 1'b1, 3'd1, 32'h21, 32'h0, 32'hAAAA5555, 1'b1);

        // SB / LBU / LB / SW / LW
        issue(0, 1'b1, 3'd0, 32'h20, 32'h3, 32'h000000AB, 1'b1);
        issue(0, 1'b0, 3'd4, 32'h23, 32'h0, 32'h0, 1'b1);
        chk("lbu_data", last_ld[0], 32'h000000AB);
        issue(0, 1'b0, 3'd0, 32'h1F, 32'h2, 32'h0, 1'b1);
        issue(0, 1'b1, 3'd2, 32'h24, 32'h0, 32'h8765ABCD, 1'b1);
        issue(0, 1'b0, 3'd2, 32'h30, 32'hFFFFFFF4, 32'h0, 1'b1);
        chk("sw_lw_data", last_ld[0], 32'h8765ABCD);
        issue(0, 1'b1, 3'd1, 32'h24, 32'h0, 32'h0000C0DE, 1'b1);
        issue(0, 1'b0, 3'd1, 32'h24, 32'h0, 32'h0, 1'b1);
        chk("sh_lh_data", last_ld[0], 32'hFFFFC0DE);

        // start re-pulsed while a load is in flight (garbage store on the bus)
        n_before = dones_seen[0];
        c0 = cyc;
        issue(0, 1'b0, 3'd2, 32'h14, 32'h0, 32'h0, 1'b0);
        is_store = 1'b1; funct3 = 3'd2; base = 32'h0; store_data = 32'hFFFFFFFF;
        start0 = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("repulse_dones", 32'(dones_seen[0] - n_before), 32'd1);
        chk("repulse_latency", 32'(last_done_cyc[0] - c0), 32'd3);

        // reset in cycle 2 of a load: no done, outputs cleared next cycle
        n_before = dones_seen[0];
        issue(0, 1'b0, 3'd2, 32'h10, 32'h0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        rst0 = 1'b1;
        cur[0].abort = cyc + 1;
        zero_cyc[0]  = cyc + 1;
        @(posedge clk);
        #1;
        rst0 = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        chk("abort_no_done", 32'(dones_seen[0] - n_before), 32'd0);
        issue(0, 1'b0, 3'd2, 32'h10, 32'h0, 32'h0, 1'b1);
        chk("post_abort_lw", last_ld[0], 32'hDEADBEEF);

        // latency-3 instance, including address wrap
        c0 = cyc;
        issue(1, 1'b0, 3'd2, 32'h0, 32'h0, 32'h0, 1'b1);
        chk("rl3_data", last_ld[1], 32'hCAFEF00D);
        chk("rl3_latency", 32'(last_done_cyc[1] - c0), 32'd5);
        issue(1, 1'b0, 3'd2, 32'hFFFFFFFC, 32'h8, 32'h0, 1'b1);
        chk("wrap_data", last_ld[1], 32'h11223344);
        issue(1, 1'b1, 3'd0, 32'h00010008, 32'h1, 32'h00000077, 1'b1);
        issue(1, 1'b0, 3'd4, 32'h9, 32'h0, 32'h0, 1'b1);
        chk("rl3_lbu_data", last_ld[1], 32'h00000077);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage for the multi-cycle RV32I core. It sits between EXECUTE and the data_memory RAM. It takes one load or store request per start pulse and computes the effective address. It drives the RAM's word address, byte enables, write data and write enable, then returns a sign- or zero-extended load result with a one-cycle done pulse. This adds the LB/LH/LW/LBU/LHU/SB/SH/SW support that the core's WRITEBACK path currently lacks.

Parameters:
ADDR_WIDTH, 16, width of the RAM word address (mem_addr); effective address bits [ADDR_WIDTH+1:2] are used and higher bits are ignored.
READ_LATENCY, 1, cycles from the clock edge that registers mem_addr in the RAM to q being valid; legal values 1..3.

Ports:
clk  in  1  system clock (CLOCK_50 domain)
rst  in  1  reset, synchronous, active-high
start  in  1  request strobe; sampled only in IDLE
is_store  in  1  1 = store, 0 = load; captured with start
funct3  in  3  RV32I load/store funct3; captured with start
base  in  32  rs1 value
offset  in  32  sign-extended immediate
store_data  in  32  rs2 value
busy  out  1  high in ISSUE, WAIT and RESP
done  out  1  one-cycle pulse in RESP
fault  out  1  valid when done=1; misaligned access or illegal funct3
load_data  out  32  extended load result; valid from done, held until the next accepted start
mem_addr  out  ADDR_WIDTH  RAM word address
mem_byte_en  out  4  RAM byte enables
mem_w_data  out  32  RAM write data
mem_w_en  out  1  RAM write enable
mem_r_data  in  32  RAM q

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; busy, done, fault, mem_w_en = 0; load_data, mem_addr, mem_byte_en, mem_w_data = 0.
- All outputs are registered.
- Reset mid-operation aborts the operation at the next edge with no done pulse.
- A store already presented in ISSUE completes its RAM write in that cycle.
- States: IDLE, ISSUE, WAIT, RESP.
- Cycle numbering: cycle 0 = the cycle in which start=1 is sampled in IDLE.
- Capture: ea = base + offset, modulo 2^32. is_store, funct3 and store_data are captured at the same time.
- Legal funct3 values:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
  - stores: 000 SB, 001 SH, 010 SW
- Fault conditions: any other funct3; a halfword access with ea[0]=1; a word access with ea[1:0]≠0.
- Fault path: next state is RESP directly; done and fault=1 in cycle 1; no RAM access (mem_w_en stays 0); load_data=0.
- IDLE → ISSUE on start with no fault. mem_addr = ea[ADDR_WIDTH+1:2] is driven from cycle 1 and held through RESP.
- Store, ISSUE (cycle 1): mem_w_en=1 for exactly one cycle.
  - SB: byte_en = 0001 << ea[1:0]; w_data = {4{store_data[7:0]}}.
  - SH: byte_en = 0011 << ea[1:0]; w_data = {2{store_data[15:0]}}.
  - SW: byte_en = 1111; w_data = store_data.
  - ISSUE → RESP; done in cycle 2; fault=0.
- Load, ISSUE (cycle 1): mem_w_en=0, byte_en=1111.
  - ISSUE → WAIT. A down-counter in WAIT runs so that mem_r_data is sampled on the edge ending cycle 1+READ_LATENCY.
  - WAIT → RESP; done and load_data valid in cycle 2+READ_LATENCY (cycle 3 at the default).
- Load extraction, using ea[1:0]:
  - LB/LBU: byte = r_data[8*ea[1:0] +: 8], sign- or zero-extended.
  - LH/LHU: half = r_data[16*ea[1] +: 16], sign- or zero-extended.
  - LW: whole word.
- RESP → IDLE unconditionally. After RESP, mem_w_en=0 and byte_en=0000; mem_addr keeps its last value.
- start is ignored while busy=1, including in RESP.
- Back-to-back requests: the earliest next accepted start is the cycle after done.
- Address wrap: ea overflow wraps modulo 2^32. Bits above ADDR_WIDTH+1 are dropped silently; they do not cause a fault.

Test Plan:
- RAM word 4 = 0xDEADBEEF; LB, base=0x10, offset=3 → mem_addr=4 in cycles 1–3; done in cycle 3; load_data=0xFFFFFFDE; fault=0.
- LHU, base=0x14, offset=0xFFFFFFFE (ea=0x12) → mem_addr=4; load_data=0x0000DEAD in cycle 3. Repeat as LH → 0xFFFFDEAD.
- SH, base=0x16, offset=0, store_data=0x12345678 → cycle 1: mem_addr=5, byte_en=1100, w_data=0x56785678, w_en=1 for one cycle; done in cycle 2. A following LW of 0x14 returns 0x5678xxxx (lower half unchanged).
- LW with ea=0x11, and a store with funct3=011 → done and fault=1 in cycle 1; mem_w_en never asserts; load_data=0.
- LW in flight with start re-pulsed in cycles 1 and 2 → only one done, in cycle 3. rst=1 in cycle 2 of another LW → no done; all outputs 0 in the next cycle.
- READ_LATENCY=3, LW ea=0x0 with RAM word 0 = 0xCAFEF00D → done in cycle 5 with 0xCAFEF00D; ea = 0xFFFFFFFC + 8 wraps to word 1.
